// File: rtl/pix_stream_pkg.sv
// Shared types and constants for the pixel stream receiver.
package pix_stream_pkg;

    typedef enum logic [0:0] {
        WAIT_SOF = 1'b0,
        RECV     = 1'b1
    } rx_state_t;

    localparam int ERR_SOF_EARLY   = 0;
    localparam int ERR_SOF_MISSING = 1;
    localparam int ERR_EOL_EARLY   = 2;
    localparam int ERR_EOL_LATE    = 3;
    localparam int ERR_KEEP        = 4;
    localparam int ERR_W           = 5;

    localparam int LAST_EOL = 0;
    localparam int LAST_EOF = 1;

    localparam int DEF_X_SIZE = 640;
    localparam int DEF_Y_SIZE = 480;

endpackage

// File: rtl/pix_rx_coord_counter.sv
// Raster x/y counter: holds the position of the next expected beat; 'origin'
// forces the current beat to (0,0), 'step' advances past the current beat.
module pix_rx_coord_counter #(
    parameter int X_SIZE = 640,
    parameter int Y_SIZE = 480,
    parameter int XW     = 10,
    parameter int YW     = 10
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          origin,
    input  logic          step,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          at_origin,
    output logic          is_eol,
    output logic          is_last
);

    localparam logic [XW-1:0] X_LAST = XW'(X_SIZE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(Y_SIZE - 1);

    logic [XW-1:0] x_reg;
    logic [YW-1:0] y_reg;

    assign x         = origin ? '0 : x_reg;
    assign y         = origin ? '0 : y_reg;
    assign at_origin = (x_reg == '0) && (y_reg == '0);
    assign is_eol    = (x == X_LAST);
    assign is_last   = is_eol && (y == Y_LAST);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            x_reg <= '0;
            y_reg <= '0;
        end else if (step) begin
            if (is_last) begin
                x_reg <= '0;
                y_reg <= '0;
            end else if (is_eol) begin
                x_reg <= '0;
                y_reg <= y + 1'b1;
            end else begin
                x_reg <= x + 1'b1;
                y_reg <= y;
            end
        end
    end

endmodule

// File: rtl/pixel_stream_receiver.sv
// AXI4-Stream video sink with framing checks, sticky error flags and a frame counter.
// Optional per-frame tdata checksum enabled by defining PIX_RX_CHECKSUM_EN.
module pixel_stream_receiver
    import pix_stream_pkg::*;
#(
    parameter int X_SIZE    = DEF_X_SIZE,
    parameter int Y_SIZE    = DEF_Y_SIZE,
    parameter int XW        = 10,
    parameter int YW        = 10,
    parameter int LAST_MODE = LAST_EOL
) (
    input  logic          in_stream_aclk,
    input  logic          periph_resetn,
    input  logic [31:0]   in_stream_tdata,
    input  logic [3:0]    in_stream_tkeep,
    input  logic          in_stream_tlast,
    input  logic          in_stream_tuser,
    input  logic          in_stream_tvalid,
    output logic          in_stream_tready,
    input  logic          rx_hold,
    input  logic          err_clr,
    output logic          pix_valid,
    output logic [31:0]   pix_data,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic          frame_done,
    output logic [15:0]   frame_count,
    output logic [4:0]    err_flags,
    output logic [31:0]   frame_checksum
);

    rx_state_t      state_reg;
    logic           tready_reg;
    logic           frame_seen_reg;
    logic           pix_valid_reg;
    logic [31:0]    pix_data_reg;
    logic [XW-1:0]  pix_x_reg;
    logic [YW-1:0]  pix_y_reg;
    logic           frame_done_reg;
    logic [15:0]    frame_count_reg;
    logic [ERR_W-1:0] err_reg, err_next, err_set;

    logic accept, sof_beat, active, last_exp;
    logic [XW-1:0] cur_x;
    logic [YW-1:0] cur_y;
    logic at_origin, is_eol, is_last;

    assign accept   = in_stream_tvalid && tready_reg;
    assign sof_beat = accept && in_stream_tuser;
    // Beats seen while hunting for SOF are dropped unless they carry tuser.
    assign active   = accept && ((state_reg == RECV) || in_stream_tuser);

    pix_rx_coord_counter #(
        .X_SIZE (X_SIZE),
        .Y_SIZE (Y_SIZE),
        .XW     (XW),
        .YW     (YW)
    ) u_coord (
        .clk       (in_stream_aclk),
        .resetn    (periph_resetn),
        .origin    (sof_beat),
        .step      (active),
        .x         (cur_x),
        .y         (cur_y),
        .at_origin (at_origin),
        .is_eol    (is_eol),
        .is_last   (is_last)
    );

    assign last_exp = (LAST_MODE == LAST_EOF) ? is_last : is_eol;

    always_comb begin
        err_set                  = '0;
        err_set[ERR_SOF_EARLY]   = sof_beat && (state_reg == RECV) && !at_origin;
        err_set[ERR_SOF_MISSING] = accept && (state_reg == WAIT_SOF) && !in_stream_tuser
                                   && frame_seen_reg;
        err_set[ERR_EOL_EARLY]   = active && in_stream_tlast && !last_exp;
        err_set[ERR_EOL_LATE]    = active && !in_stream_tlast && last_exp;
        err_set[ERR_KEEP]        = active && (in_stream_tkeep != 4'hF);
    end

    // A new error in the clearing cycle survives the clear.
    for (genvar gi = 0; gi < ERR_W; gi++) begin : g_err
        assign err_next[gi] = err_set[gi] || (err_reg[gi] && !err_clr);
    end

    always_ff @(posedge in_stream_aclk) begin
        if (!periph_resetn) begin
            state_reg       <= WAIT_SOF;
            tready_reg      <= 1'b0;
            frame_seen_reg  <= 1'b0;
            pix_valid_reg   <= 1'b0;
            pix_data_reg    <= '0;
            pix_x_reg       <= '0;
            pix_y_reg       <= '0;
            frame_done_reg  <= 1'b0;
            frame_count_reg <= '0;
            err_reg         <= '0;
        end else begin
            tready_reg     <= !rx_hold;
            pix_valid_reg  <= active;
            frame_done_reg <= active && is_last;
            err_reg        <= err_next;
            if (active) begin
                pix_data_reg <= in_stream_tdata;
                pix_x_reg    <= cur_x;
                pix_y_reg    <= cur_y;
                if (is_last) begin
                    state_reg       <= WAIT_SOF;
                    frame_count_reg <= frame_count_reg + 16'd1;
                    frame_seen_reg  <= 1'b1;
                end else begin
                    state_reg <= RECV;
                end
            end
        end
    end

`ifdef PIX_RX_CHECKSUM_EN
    logic [31:0] sum_reg, sum_next, checksum_reg;

    assign sum_next = (sof_beat ? 32'd0 : sum_reg) + in_stream_tdata;

    always_ff @(posedge in_stream_aclk) begin
        if (!periph_resetn) begin
            sum_reg      <= '0;
            checksum_reg <= '0;
        end else if (active) begin
            sum_reg <= sum_next;
            if (is_last) begin
                checksum_reg <= sum_next;
            end
        end
    end

    assign frame_checksum = checksum_reg;
`else
    assign frame_checksum = '0;
`endif

    assign in_stream_tready = tready_reg;
    assign pix_valid        = pix_valid_reg;
    assign pix_data         = pix_data_reg;
    assign pix_x            = pix_x_reg;
    assign pix_y            = pix_y_reg;
    assign frame_done       = frame_done_reg;
    assign frame_count      = frame_count_reg;
    assign err_flags        = err_reg;

endmodule

// File: doc/pixel_stream_receiver.md
Name: pixel_stream_receiver

Overview:
AXI4-Stream video sink. It is the receiving end of the pixel_generator output stream and sits on the consumer side of the pixel stream, in loopback benches or in front of a frame checker. It tracks the x/y position of each beat, checks tuser (start of frame) and tlast framing against the configured geometry, and presents accepted pixels with their coordinates. Errors are reported through sticky flags, and a frame counter counts completed frames.

Parameters:
X_SIZE, 640, pixels per line
Y_SIZE, 480, lines per frame
XW, 10, x counter width (must satisfy 2^XW >= X_SIZE)
YW, 10, y counter width (must satisfy 2^YW >= Y_SIZE)
LAST_MODE, 0, 0 = tlast marks end of line; 1 = tlast marks end of frame only

Ports:
in_stream_aclk  in  1  single clock
periph_resetn  in  1  synchronous, active-low reset
in_stream_tdata  in  32  pixel data
in_stream_tkeep  in  4  byte enables; 4'hF is required
in_stream_tlast  in  1  end marker (meaning set by LAST_MODE)
in_stream_tuser  in  1  start of frame, asserted on pixel (0,0)
in_stream_tvalid  in  1  source valid
in_stream_tready  out  1  sink ready
rx_hold  in  1  request backpressure
err_clr  in  1  clear all sticky error flags
pix_valid  out  1  accepted pixel strobe
pix_data  out  32  accepted pixel data
pix_x  out  XW  x coordinate of the accepted pixel
pix_y  out  YW  y coordinate of the accepted pixel
frame_done  out  1  one-cycle pulse on the last pixel of a frame
frame_count  out  16  completed frames, wraps 0xFFFF to 0
err_flags  out  5  sticky flags: [0] sof_early, [1] sof_missing, [2] eol_early, [3] eol_late, [4] keep
frame_checksum  out  32  see Optional Feature

Behaviour:
- Clocking and reset: one clock, in_stream_aclk. Reset is synchronous and active-low on periph_resetn.
- Reset values: all outputs are 0 and the FSM is in WAIT_SOF.
- tready: registered; in_stream_tready <= ~rx_hold. It is therefore 0 during reset and in the first cycle after reset release. A change on rx_hold takes effect one cycle later.
- Accept: a beat is accepted when tvalid && tready. No other condition matters.
- FSM state WAIT_SOF:
  - Accepted beat with tuser=0 is discarded and produces no pix_valid.
  - sof_missing is set on such a beat only if at least one frame has completed since reset.
  - Accepted beat with tuser=1 becomes pixel (0,0); go to RECV.
- FSM state RECV, per accepted beat:
  - Coordinates: x advances; at X_SIZE-1, x returns to 0 and y increments.
  - Last pixel (X_SIZE-1, Y_SIZE-1): pulse frame_done, increment frame_count, go to WAIT_SOF.
  - tuser=1 at any position other than (0,0): set sof_early and resynchronise, treating the beat as the new (0,0).
- tlast check, on every non-discarded beat:
  - Expected tlast is (x==X_SIZE-1) when LAST_MODE=0, or (x==X_SIZE-1 && y==Y_SIZE-1) when LAST_MODE=1.
  - tlast=1 when not expected sets eol_early; tlast=0 when expected sets eol_late.
  - Coordinate counting is never altered by tlast.
- tkeep check: tkeep != 4'hF on a non-discarded beat sets the keep flag. The data is still delivered.
- Latency: exactly 1 cycle. pix_valid/pix_data/pix_x/pix_y are registered in the cycle after acceptance; frame_done is aligned with the pix_valid of the last pixel.
- Error flags: sticky until err_clr. If a set and err_clr occur in the same cycle, the set wins.
- Back-to-back frames: a SOF beat immediately following the last pixel is accepted with no bubble.
- Reset mid-frame: all state is discarded, including frame_count and the error flags. The block returns to WAIT_SOF.

Optional Feature:
- Macro: PIX_RX_CHECKSUM_EN.
- Defined: a 32-bit running sum (mod 2^32) of the tdata of every pixel in the current frame. It restarts at SOF, including a resync SOF. The sum is latched to frame_checksum on the frame_done cycle and held until the next frame_done or reset.
- Undefined: frame_checksum is tied to 0 and no adder is built.

Decomposition:
- Package pix_stream_pkg:
  - rx_state_t enum (WAIT_SOF, RECV)
  - error bit index constants (ERR_SOF_EARLY, ERR_SOF_MISSING, ERR_EOL_EARLY, ERR_EOL_LATE, ERR_KEEP)
  - LAST_MODE encodings (LAST_EOL, LAST_EOF)
  - default X_SIZE and Y_SIZE
- Sub-module pix_rx_coord_counter: x/y counter with wrap, load-to-origin, and an is_last output.

Test Plan:
All scenarios use X_SIZE=4, Y_SIZE=3.
1. LAST_MODE=0, rx_hold=0, 12 beats with data 0..11, SOF on beat 0, tlast at x=3 -> 12 pix_valid with (x,y) from (0,0) to (3,2); frame_done on the 12th; frame_count=1; err_flags=0; checksum=66.
2. 5 beats with tuser=0 right after reset, then a clean frame -> first 5 beats discarded, no pix_valid from them, err_flags=0, frame_count=1.
3. SOF re-asserted on beat 6 of a frame -> err_flags[0]=1 and that beat emitted as (0,0); frame_done 12 beats later; frame_count=1.
4. tlast on beat at x=1, and tlast omitted at x=3 of the same line -> err_flags=5'b01100; err_clr pulse -> err_flags=0.
5. rx_hold high for 3 cycles mid-line with tvalid held -> tready low for 3 cycles starting one cycle later; no beat lost or duplicated; frame completes with checksum=66.
6. periph_resetn low for 1 cycle at beat 7 -> all outputs 0 and tready 0 in the following cycle; the next SOF frame completes with frame_count=1.
